uart_word_tx: RTL and testbench
===============================

// Module: uart_word_tx
// PURPOSE
//   Transmit half of the UART debug link: accepts DATA_WIDTH-bit words on a valid/ready
//   port, buffers them in an internal FIFO and serialises each word as DATA_WIDTH/8
//   8N1 frames on uart_txd, least-significant byte first.
//   It sits between the debug data source and the board TX pin and pairs with the
//   existing word-assembling UART receiver.
// PARAMETERS
//   CLK_FREQ    200000000  sys_clk frequency in Hz
//   UART_BPS    9600       line rate; BAUD_DIV = CLK_FREQ/UART_BPS (integer, truncated), BAUD_DIV >= 2
//   DATA_WIDTH  32         word width; must be a multiple of 8 and >= 8
//   FIFO_DEPTH  42         words buffered; any value >= 2, not restricted to powers of two
// PORTS
//   sys_clk     in   1                         system clock, all logic on rising edge
//   sys_rst     in   1                         synchronous reset, active-high
//   tx_data     in   DATA_WIDTH                word to send, sampled when tx_valid && tx_ready
//   tx_valid    in   1                         source has a word
//   tx_ready    out  1                         FIFO can accept a word this cycle
//   uart_txd    out  1                         serial line, idles high
//   tx_busy     out  1                         frame in progress or FIFO non-empty
//   fifo_count  out  $clog2(FIFO_DEPTH+1)      words currently held in the FIFO
// BEHAVIOUR
//   Reset (synchronous, sys_rst high at a clock edge):
//   - uart_txd=1, tx_ready=1, tx_busy=0, fifo_count=0.
//   - FIFO pointers cleared, FSM set to IDLE.
//   - Reset mid-frame aborts immediately: line high from the next edge, all queued words discarded.
//   FIFO:
//   - Circular buffer with wrap at FIFO_DEPTH-1 -> 0.
//   - tx_ready = (fifo_count < FIFO_DEPTH), derived from registered count; no cycle-level dependence on pop.
//   - Push when full is not accepted, even if a pop occurs in the same cycle.
//   - Push and pop in the same cycle leave fifo_count unchanged.
//   FSM states:
//   - IDLE: if FIFO non-empty, pop the head word into shift register sreg, byte_idx=0 -> START.
//   - START: uart_txd=0 for BAUD_DIV cycles -> DATA, bit_idx=0.
//   - DATA: uart_txd = sreg[bit_idx] of the current byte, LSB first, BAUD_DIV cycles per bit;
//     after bit 7 -> STOP.
//   - STOP: uart_txd=1 for BAUD_DIV cycles. Then:
//       - byte_idx < DATA_WIDTH/8-1: byte_idx++, shift sreg right 8 -> START.
//       - else, FIFO non-empty: pop the next word and go directly to START (no idle gap).
//       - else -> IDLE.
//   Timing:
//   - uart_txd registered; a baud counter 0..BAUD_DIV-1 restarts on every state entry.
//   - Frame = 10*BAUD_DIV cycles; word = DATA_WIDTH/8 frames back to back.
//   - Latency: word accepted at edge N into an empty idle block -> pop at edge N+1,
//     uart_txd low from edge N+2.
//   - tx_busy = (state != IDLE) || (fifo_count != 0).
//   - tx_data is ignored when tx_valid is low; tx_valid may drop without handshake completion.
// TESTING (CLK_FREQ=1000, UART_BPS=100 -> BAUD_DIV=10, FIFO_DEPTH=4)
//   1 Reset for 3 cycles, then idle 50 cycles -> uart_txd=1, tx_ready=1, tx_busy=0,
//     fifo_count=0 throughout.
//   2 Push 0x12345678 once -> start bit 2 cycles after accept; a UART monitor decodes
//     bytes 0x78,0x56,0x34,0x12 in that order; 400 cycles line-active; tx_busy falls right after.
//   3 Push 6 words back to back with tx_valid held -> the first 5 are accepted (one popped
//     immediately, 4 buffered); tx_ready low when count=4; the 6th is taken after the first
//     word finishes; 24 contiguous frames with no idle gap between words.
//   4 Assert sys_rst during bit 3 of byte 2 with 3 words queued -> uart_txd=1 next cycle;
//     fifo_count=0; nothing further sent; the next push transmits only the new word.
//   5 Full FIFO plus tx_valid held high in the cycle the FSM pops -> that push is refused;
//     it is accepted the following cycle; total words decoded equals total handshakes.
//   6 Push 0xFFFFFFFF then 0x00000000 -> each bit period is exactly 10 cycles and each stop
//     bit is exactly 10 cycles high, measured at the line.

Source files
------------

// File: rtl/uart_word_tx.sv
// uart_word_tx
//   Transmit half of the UART debug link. Words arrive on a valid/ready port,
//   are buffered in a circular FIFO, and each word is sent as DATA_WIDTH/8
//   8N1 frames on uart_txd, least-significant byte first. When the FIFO still
//   holds data, words follow each other with no idle gap on the line.
//
//   State table:
//     IDLE  | line high, waiting for a word in the FIFO
//     START | start bit (low) for one bit period
//     DATA  | eight data bits of the current byte, LSB first
//     STOP  | stop bit (high); then next byte, next word, or IDLE
//
// Ports
//   sys_clk    in   system clock, rising edge
//   sys_rst    in   synchronous reset, active-high
//   tx_data    in   word to send, taken when tx_valid && tx_ready
//   tx_valid   in   source has a word
//   tx_ready   out  FIFO has room (from the registered count)
//   uart_txd   out  registered serial line, idles high
//   tx_busy    out  frame in progress or FIFO non-empty
//   fifo_count out  words currently held in the FIFO
module uart_word_tx #(
  parameter int CLK_FREQ   = 200000000,
  parameter int UART_BPS   = 9600,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 42
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst,
  input  logic [DATA_WIDTH-1:0]             tx_data,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  output logic                              uart_txd,
  output logic                              tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int BAUD_DIV = CLK_FREQ / UART_BPS;
  localparam int BAUD_W   = $clog2(BAUD_DIV);
  localparam int NBYTES   = DATA_WIDTH / 8;
  localparam int BYTE_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic [2:0]              bit_q, bit_d;
  logic [BYTE_W-1:0]       byte_q, byte_d;
  logic [DATA_WIDTH-1:0]   sreg_q, sreg_d;
  logic                    txd_q, txd_d;

  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;

  logic push;
  logic pop;
  logic baud_end;

  // Ready comes only from the registered count, so a pop in the same cycle
  // never opens a slot for a push.
  assign tx_ready   = (count_q < CNT_W'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign baud_end   = (baud_q == BAUD_W'(BAUD_DIV - 1));
  assign uart_txd   = txd_q;
  assign tx_busy    = (state_q != IDLE) || (count_q != '0);
  assign fifo_count = count_q;

  // Serialiser next state. The baud counter restarts on every state entry
  // and on every data-bit boundary.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BAUD_W'(1);
    bit_d   = bit_q;
    byte_d  = byte_q;
    sreg_d  = sreg_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          sreg_d  = mem_q[rd_ptr_q];
          byte_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (byte_q != BYTE_W'(NBYTES - 1)) begin
            byte_d  = byte_q + BYTE_W'(1);
            sreg_d  = sreg_q >> 8;
            state_d = START;
          end else if (count_q != '0) begin
            // Chain straight into the next word without an idle cycle.
            pop     = 1'b1;
            sreg_d  = mem_q[rd_ptr_q];
            byte_d  = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line level is registered, so it trails the state by one cycle.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_q)
      START:   txd_d = 1'b0;
      DATA:    txd_d = sreg_q[bit_q];
      default: txd_d = 1'b1;
    endcase
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      sreg_q   <= '0;
      txd_q    <= 1'b1;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      sreg_q   <= sreg_d;
      txd_q    <= txd_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
module tb_uart_word_tx;
  localparam int CLK_FREQ = 1000;
  localparam int UART_BPS = 100;
  localparam int DW       = 32;
  localparam int DEPTH    = 4;
  localparam int BD       = 10;
  localparam int FRAME    = 10 * BD;
  localparam int WORD_CYC = 4 * FRAME;
  localparam int CW       = $clog2(DEPTH + 1);

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic          uart_txd;
  logic          tx_busy;
  logic [CW-1:0] fifo_count;

  always #5 sys_clk = ~sys_clk;

  uart_word_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .UART_BPS  (UART_BPS),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .uart_txd  (uart_txd),
    .tx_busy   (tx_busy),
    .fifo_count(fifo_count)
  );

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endfunction

  // Word-level reference: a queue for the FIFO, and for each popped word the
  // edge it left the FIFO; the line waveform follows from frame arithmetic.
  int          cyc = 0;
  logic [31:0] m_fifo[$];
  bit          m_active = 0;
  int          m_end = 0;
  bit          m_pop, m_push;
  int          last_pop = -100000;
  logic [31:0] cur_w = '0, prev_w = '0;
  int          cur_p = -100000, prev_p = -100000;
  logic        exp_txd = 1'b1, exp_ready = 1'b1, exp_busy = 1'b0;
  int          exp_count = 0;
  logic [7:0]  exp_bytes[$];

  function automatic logic line_bit(logic [31:0] w, int j);
    int b, pos;
    b   = j / FRAME;
    pos = (j % FRAME) / BD;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return w[8*b + pos - 1];
  endfunction

  always @(posedge sys_clk) begin
    cyc++;
    if (sys_rst) begin
      m_fifo.delete();
      exp_bytes.delete();
      m_active = 0;
      cur_p    = -100000;
      prev_p   = -100000;
    end else begin
      m_push = tx_valid && (m_fifo.size() < DEPTH);
      m_pop  = 0;
      if (m_active && cyc == m_end) begin
        if (m_fifo.size() > 0) m_pop = 1;
        else m_active = 0;
      end else if (!m_active && m_fifo.size() > 0) begin
        m_pop = 1;
      end
      if (m_pop) begin
        prev_w   = cur_w;
        prev_p   = cur_p;
        cur_w    = m_fifo.pop_front();
        cur_p    = cyc;
        m_active = 1;
        m_end    = cyc + WORD_CYC;
        last_pop = cyc;
      end
      if (m_push) begin
        m_fifo.push_back(tx_data);
        for (int i = 0; i < 4; i++) exp_bytes.push_back(tx_data[8*i +: 8]);
      end
    end
    exp_txd = 1'b1;
    if (cyc - cur_p - 1 >= 0 && cyc - cur_p - 1 < WORD_CYC)
      exp_txd = line_bit(cur_w, cyc - cur_p - 1);
    else if (cyc - prev_p - 1 >= 0 && cyc - prev_p - 1 < WORD_CYC)
      exp_txd = line_bit(prev_w, cyc - prev_p - 1);
    exp_ready = (m_fifo.size() < DEPTH);
    exp_busy  = m_active || (m_fifo.size() > 0);
    exp_count = m_fifo.size();
  end

  // Per-cycle compare plus a line-level UART decoder and run-length recorder.
  bit         chk_en = 0;
  int         mon_state = 0;
  int         mon_cnt = 0;
  int         mon_k;
  logic [7:0] mon_sh = '0;
  int         mon_idx = 0;
  logic [7:0] dec_log[$];
  bit         rec_en = 0;
  logic       rec_prev = 1'b1;
  int         rec_run = 0;
  int         runs[$];

  always @(negedge sys_clk) begin
    if (chk_en) begin
      chk("uart_txd", {31'd0, uart_txd}, {31'd0, exp_txd});
      chk("tx_ready", {31'd0, tx_ready}, {31'd0, exp_ready});
      chk("tx_busy", {31'd0, tx_busy}, {31'd0, exp_busy});
      chk("fifo_count", 32'(fifo_count), exp_count);
    end
    if (sys_rst) begin
      mon_state = 0;
      mon_idx   = 0;
    end else if (mon_state == 0) begin
      if (uart_txd == 1'b0) begin
        mon_state = 1;
        mon_cnt   = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == BD / 2) begin
        if (uart_txd != 1'b0) mon_state = 0;
      end else if (mon_cnt > BD / 2 && (mon_cnt - BD / 2) % BD == 0) begin
        mon_k = (mon_cnt - BD / 2) / BD;
        if (mon_k <= 8) begin
          mon_sh[mon_k-1] = uart_txd;
        end else begin
          chk("stop_bit", {31'd0, uart_txd}, 32'd1);
          dec_log.push_back(mon_sh);
          if (mon_idx < exp_bytes.size()) chk("rx_byte", {24'd0, mon_sh}, {24'd0, exp_bytes[mon_idx]});
          else chk("rx_byte_unexpected", mon_idx, exp_bytes.size());
          mon_idx++;
          mon_state = 0;
        end
      end
    end
    if (rec_en) begin
      if (uart_txd == rec_prev) rec_run++;
      else begin
        runs.push_back(rec_run);
        rec_run  = 1;
        rec_prev = uart_txd;
      end
    end else begin
      rec_prev = 1'b1;
      rec_run  = 0;
    end
  end

  task automatic send_word(input logic [31:0] d, output int acc);
    acc = -1;
    for (int w = 0; w < 2000; w++) begin
      @(negedge sys_clk);
      tx_valid = 1'b1;
      tx_data  = d;
      if (tx_ready) begin
        @(posedge sys_clk);
        #1;
        acc = cyc;
        break;
      end
    end
    chk("accept_timeout", {31'd0, acc < 0}, 32'd0);
  endtask

  task automatic release_valid();
    @(negedge sys_clk);
    tx_valid = 1'b0;
    tx_data  = $urandom;
  endtask

  task automatic wait_idle(input int limit);
    int k;
    for (k = 0; k < limit; k++) begin
      @(posedge sys_clk);
      #1;
      if (!m_active && m_fifo.size() == 0) break;
    end
    chk("idle_timeout", {31'd0, k >= limit}, 32'd0);
    repeat (10) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int acc, base, k, b, base_r;
    int accs[7];
    logic [31:0] words[7];
    logic [7:0] lit2[4];
    int lit_runs[15];

    // Reset then quiet line.
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    chk_en = 1;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    repeat (50) begin
      @(posedge sys_clk);
      #1;
      chk("idle_txd", {31'd0, uart_txd}, 32'd1);
      chk("idle_ready", {31'd0, tx_ready}, 32'd1);
      chk("idle_busy", {31'd0, tx_busy}, 32'd0);
      chk("idle_count", 32'(fifo_count), 32'd0);
    end

    // Single word: latency, decode order, busy length.
    base = dec_log.size();
    send_word(32'h12345678, acc);
    release_valid();
    for (k = 1; k < 20; k++) begin
      @(posedge sys_clk);
      #1;
      if (uart_txd == 1'b0) break;
    end
    chk("start_latency", k, 2);
    for (b = 1; b < 1000; b++) begin
      @(posedge sys_clk);
      #1;
      if (!tx_busy) break;
    end
    chk("busy_fall", b, 399);
    wait_idle(1000);
    lit2 = '{8'h78, 8'h56, 8'h34, 8'h12};
    chk("w1_nbytes", dec_log.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (base + i < dec_log.size()) chk("w1_byte", {24'd0, dec_log[base+i]}, {24'd0, lit2[i]});

    // Six words with valid held: fifth fills the FIFO, sixth waits for a pop.
    base = dec_log.size();
    for (int i = 0; i < 6; i++) begin
      words[i] = $urandom;
      send_word(words[i], accs[i]);
    end
    release_valid();
    chk("fifth_accept", accs[4] - accs[0], 4);
    chk("sixth_accept", accs[5] - accs[0], 402);
    wait_idle(4000);
    chk("burst_nbytes", dec_log.size() - base, 24);
    for (int i = 0; i < 24; i++)
      if (base + i < dec_log.size())
        chk("burst_byte", {24'd0, dec_log[base+i]}, {24'd0, words[i/4][8*(i%4) +: 8]});

    // Reset in the middle of bit 3 of the second byte with 3 words queued.
    for (int i = 0; i < 4; i++) begin
      send_word($urandom, acc);
    end
    release_valid();
    chk("pre_rst_count", 32'(fifo_count), 32'd3);
    for (k = 0; k < 1000 && cyc < last_pop + 1 + FRAME + 4 * BD + 3; k++) begin
      @(posedge sys_clk);
      #1;
    end
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    chk("rst_txd", {31'd0, uart_txd}, 32'd1);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    repeat (150) @(posedge sys_clk);
    #1;
    base = dec_log.size();
    send_word(32'hCAFEF00D, acc);
    release_valid();
    wait_idle(1000);
    lit2 = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
    chk("post_rst_nbytes", dec_log.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (base + i < dec_log.size()) chk("post_rst_byte", {24'd0, dec_log[base+i]}, {24'd0, lit2[i]});

    // Full FIFO with valid held across the pop: refused then, taken one edge later.
    base = dec_log.size();
    for (int i = 0; i < 7; i++) begin
      send_word($urandom, accs[i]);
      if (i >= 5) chk("full_accept_after_pop", accs[i] - last_pop, 1);
    end
    release_valid();
    wait_idle(4000);
    chk("full_nbytes", dec_log.size() - base, 28);

    // All-ones then all-zeros: exact run lengths at the line.
    @(posedge sys_clk);
    #1;
    rec_en = 1;
    base_r = runs.size();
    send_word(32'hFFFFFFFF, acc);
    send_word(32'h00000000, acc);
    release_valid();
    wait_idle(2000);
    rec_en = 0;
    lit_runs = '{10, 90, 10, 90, 10, 90, 10, 90, 90, 10, 90, 10, 90, 10, 90};
    chk("run_count", runs.size() - base_r, 16);
    for (int i = 0; i < 15; i++)
      if (base_r + 1 + i < runs.size()) chk("run_len", runs[base_r+1+i], lit_runs[i]);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      @(negedge sys_clk);
      tx_valid = ($urandom_range(0, 15) == 0);
      tx_data  = $urandom;
    end
    release_valid();
    wait_idle(3000);
    chk("bytes_drained", mon_idx, exp_bytes.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
